imem_arbiter: RTL and testbench

- Sequences a single-port, synchronous-read instruction memory and shares it between two requesters: the core fetch unit (F, read-only) and the program loader/debug port (L, read/write).
- Sits between the fetch stage and the instruction memory array.
- Provides valid/ready handshakes, fair arbitration, a loader lock for program download, and misalignment error responses.

---
 rtl/imem_arbiter_if.sv | 56 +++++
 rtl/imem_arbiter.sv | 108 ++++++++++
 tb/tb_imem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters (fetch, loader)
// and the single-port synchronous-read memory array.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

interface imem_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DW     = `INST_WIDTH
);
    // Fetch port (read-only)
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DW-1:0]     f_rdata;
    logic              f_err;

    // Loader / debug port (read-write)
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DW-1:0]     l_wdata;
    logic              l_lock;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DW-1:0]     l_rdata;
    logic              l_err;

    // Memory array side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    // Arbiter view
    modport slave (
        input  f_req, f_addr,
        input  l_req, l_we, l_addr, l_wdata, l_lock,
        input  mem_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output l_gnt, l_rvalid, l_rdata, l_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requester / memory environment view
    modport master (
        output f_req, f_addr,
        output l_req, l_we, l_addr, l_wdata, l_lock,
        output mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  l_gnt, l_rvalid, l_rdata, l_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Shares one single-port synchronous-read instruction memory between the fetch unit and
// the loader: round-robin on contention, loader lock, misaligned accesses answered with err.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module imem_arbiter #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned DW       = `INST_WIDTH,
    localparam int unsigned ADDR_W  = $clog2(MEM_SIZE)
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_arbiter_if.slave  bus
);

    typedef enum logic {WinF, WinL} winner_e;

    winner_e           last_winner_q, last_winner_d;
    logic              f_gnt_w, l_gnt_w;
    logic [ADDR_W-1:0] sel_addr;
    logic              misaligned;
    logic              mem_en_w;

    logic              f_rvalid_q, f_err_q, f_rd_q;
    logic              l_rvalid_q, l_err_q, l_rd_q;
    logic [DW-1:0]     f_rdata_w, l_rdata_w;

    // Grants are suppressed while reset is held so every output sits at its reset value.
    always_comb begin
        f_gnt_w       = 1'b0;
        l_gnt_w       = 1'b0;
        last_winner_d = last_winner_q;
        if (!rst_n) begin
            f_gnt_w = 1'b0;
            l_gnt_w = 1'b0;
        end else if (bus.l_lock) begin
            l_gnt_w = bus.l_req;
        end else if (bus.f_req && bus.l_req) begin
            if (last_winner_q == WinL) begin
                f_gnt_w       = 1'b1;
                last_winner_d = WinF;
            end else begin
                l_gnt_w       = 1'b1;
                last_winner_d = WinL;
            end
        end else begin
            f_gnt_w = bus.f_req;
            l_gnt_w = bus.l_req;
        end
    end

    always_comb begin
        sel_addr   = l_gnt_w ? bus.l_addr : bus.f_addr;
        misaligned = (sel_addr[1:0] != 2'b00);
        mem_en_w   = (f_gnt_w | l_gnt_w) & ~misaligned;
    end

    assign bus.f_gnt     = f_gnt_w;
    assign bus.l_gnt     = l_gnt_w;
    assign bus.mem_en    = mem_en_w;
    assign bus.mem_we    = mem_en_w & l_gnt_w & bus.l_we;
    assign bus.mem_addr  = mem_en_w ? sel_addr[ADDR_W-1:2] : '0;
    assign bus.mem_wdata = mem_en_w ? bus.l_wdata : '0;

    // f_rd_q / l_rd_q mark an aligned read whose data arrives on mem_rdata this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner_q <= WinL;
            f_rvalid_q    <= 1'b0;
            f_err_q       <= 1'b0;
            f_rd_q        <= 1'b0;
            l_rvalid_q    <= 1'b0;
            l_err_q       <= 1'b0;
            l_rd_q        <= 1'b0;
        end else begin
            last_winner_q <= last_winner_d;
            f_rvalid_q    <= f_gnt_w;
            f_err_q       <= f_gnt_w & misaligned;
            f_rd_q        <= f_gnt_w & ~misaligned;
            l_rvalid_q    <= l_gnt_w;
            l_err_q       <= l_gnt_w & misaligned;
            l_rd_q        <= l_gnt_w & ~misaligned & ~bus.l_we;
        end
    end

    always_comb begin
        f_rdata_w = f_rd_q ? bus.mem_rdata : '0;
        l_rdata_w = l_rd_q ? bus.mem_rdata : '0;
    end

    assign bus.f_rvalid = f_rvalid_q;
    assign bus.f_err    = f_err_q;
    assign bus.f_rdata  = f_rdata_w;
    assign bus.l_rvalid = l_rvalid_q;
    assign bus.l_err    = l_err_q;
    assign bus.l_rdata  = l_rdata_w;

`ifndef SYNTHESIS
    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(f_gnt_w && l_gnt_w));
    a_lock_blocks_fetch: assert property (@(posedge clk) disable iff (!rst_n)
        bus.l_lock |-> !f_gnt_w);
    a_one_response: assert property (@(posedge clk) disable iff (!rst_n)
        !(f_rvalid_q && l_rvalid_q));
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level reference model.
module tb_imem_arbiter;
    localparam int unsigned MEM_SIZE = 1024;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DW       = 32;
    localparam int unsigned WORDS    = MEM_SIZE / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    imem_arbiter_if #(.ADDR_W(ADDR_W), .DW(DW)) bus ();

    imem_arbiter #(.MEM_SIZE(MEM_SIZE), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory array environment: synchronous read, data valid the cycle after mem_en.
    logic [DW-1:0] mem_array [WORDS];
    logic [DW-1:0] mem_rdata_q = '0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_array[bus.mem_addr] <= bus.mem_wdata;
            else            mem_rdata_q <= mem_array[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mem_rdata_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h0050_0093 : (32'hA000_0000 | 32'(i));
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom_range(0, WORDS - 1)) << 2;
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // Reference model: who won the last contention, expected memory contents, and the
    // response each port must see in the following cycle.
    bit            lw_l = 1'b1;
    logic [31:0]   ref_mem [WORDS];
    bit            exp_fv, exp_fe, exp_lv, exp_le;
    logic [31:0]   exp_fd, exp_ld;
    bit            last_fg, last_lg;

    always @(negedge clk) begin : model
        bit eg_f, eg_l, mis, en, wr;
        logic [ADDR_W-1:0] a;
        int idx;
        if (!rst_n) begin
            chk("rst_f_gnt", bus.f_gnt, 0);
            chk("rst_l_gnt", bus.l_gnt, 0);
            chk("rst_f_rvalid", bus.f_rvalid, 0);
            chk("rst_l_rvalid", bus.l_rvalid, 0);
            chk("rst_f_rdata", bus.f_rdata, 0);
            chk("rst_l_rdata", bus.l_rdata, 0);
            chk("rst_f_err", bus.f_err, 0);
            chk("rst_l_err", bus.l_err, 0);
            chk("rst_mem_en", bus.mem_en, 0);
            chk("rst_mem_we", bus.mem_we, 0);
            exp_fv = 0; exp_fe = 0; exp_fd = '0;
            exp_lv = 0; exp_le = 0; exp_ld = '0;
            lw_l = 1'b1; last_fg = 0; last_lg = 0;
        end else begin
            if (bus.l_lock) begin
                eg_f = 0; eg_l = bus.l_req;
            end else if (bus.f_req && bus.l_req) begin
                eg_f = lw_l; eg_l = !lw_l;
            end else begin
                eg_f = bus.f_req; eg_l = bus.l_req;
            end
            a   = eg_l ? bus.l_addr : bus.f_addr;
            idx = int'(a) / 4;
            mis = (int'(a) % 4) != 0;
            en  = (eg_f || eg_l) && !mis;
            wr  = en && eg_l && bus.l_we;

            chk("f_gnt", bus.f_gnt, eg_f);
            chk("l_gnt", bus.l_gnt, eg_l);
            chk("mem_en", bus.mem_en, en);
            chk("mem_we", bus.mem_we, wr);
            if (en) chk("mem_addr", bus.mem_addr, idx);
            if (wr) chk("mem_wdata", bus.mem_wdata, bus.l_wdata);
            if (!eg_f && !eg_l) begin
                chk("idle_mem_addr", bus.mem_addr, 0);
                chk("idle_mem_wdata", bus.mem_wdata, 0);
            end
            chk("f_rvalid", bus.f_rvalid, exp_fv);
            chk("f_err", bus.f_err, exp_fe);
            chk("f_rdata", bus.f_rdata, exp_fd);
            chk("l_rvalid", bus.l_rvalid, exp_lv);
            chk("l_err", bus.l_err, exp_le);
            chk("l_rdata", bus.l_rdata, exp_ld);

            if (!bus.l_lock && bus.f_req && bus.l_req) lw_l = eg_l;
            exp_fv = eg_f;
            exp_fe = eg_f && mis;
            exp_fd = (eg_f && !mis) ? ref_mem[idx] : '0;
            exp_lv = eg_l;
            exp_le = eg_l && mis;
            exp_ld = (eg_l && !mis && !bus.l_we) ? ref_mem[idx] : '0;
            if (wr) ref_mem[idx] = bus.l_wdata;
            last_fg = eg_f;
            last_lg = eg_l;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.f_req = 0; bus.f_addr = '0;
        bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0; bus.l_lock = 0;
        for (int i = 0; i < int'(WORDS); i++) begin
            mem_array[i] = init_word(i);
            ref_mem[i]   = init_word(i);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single aligned fetch of word 4
        bus.f_req = 1; bus.f_addr = 10'h010;
        #1;
        chk("t1_f_gnt", bus.f_gnt, 1);
        chk("t1_mem_addr", bus.mem_addr, 4);
        tick(); bus.f_req = 0; #1;
        chk("t1_f_rvalid", bus.f_rvalid, 1);
        chk("t1_f_rdata", bus.f_rdata, 32'h0050_0093);
        chk("t1_f_err", bus.f_err, 0);

        // Contention: F wins first, then alternate
        tick(); bus.f_req = 1; bus.f_addr = 10'h000;
        bus.l_req = 1; bus.l_we = 0; bus.l_addr = 10'h008; #1;
        chk("t2_c0_f_gnt", bus.f_gnt, 1);
        chk("t2_c0_l_gnt", bus.l_gnt, 0);
        tick(); #1;
        chk("t2_c1_l_gnt", bus.l_gnt, 1);
        chk("t2_c1_f_rdata", bus.f_rdata, 32'hA000_0000);
        tick(); #1;
        chk("t2_c2_f_gnt", bus.f_gnt, 1);
        chk("t2_c2_l_rdata", bus.l_rdata, 32'hA000_0002);
        chk("t2_c2_f_rvalid", bus.f_rvalid, 0);
        tick(); #1;
        chk("t2_c3_l_gnt", bus.l_gnt, 1);
        chk("t2_c3_f_rvalid", bus.f_rvalid, 1);
        tick(); bus.f_req = 0; bus.l_req = 0; #1;
        chk("t2_c4_l_rvalid", bus.l_rvalid, 1);

        // Locked loader write while fetch keeps requesting
        tick(); bus.l_lock = 1; bus.l_req = 1; bus.l_we = 1; bus.l_addr = 10'h020;
        bus.l_wdata = 32'hDEAD_BEEF; bus.f_req = 1; bus.f_addr = 10'h020; #1;
        chk("t3_f_gnt_locked", bus.f_gnt, 0);
        chk("t3_l_gnt", bus.l_gnt, 1);
        chk("t3_mem_we", bus.mem_we, 1);
        tick(); bus.l_req = 0; #1;
        chk("t3_l_rvalid", bus.l_rvalid, 1);
        chk("t3_l_rdata", bus.l_rdata, 0);
        chk("t3_f_gnt_still_locked", bus.f_gnt, 0);
        tick(); bus.l_lock = 0; #1;
        chk("t3_f_gnt_unlocked", bus.f_gnt, 1);
        tick(); bus.f_req = 0; #1;
        chk("t3_f_rdata", bus.f_rdata, 32'hDEAD_BEEF);

        // Misaligned fetch and misaligned loader write
        tick(); bus.f_req = 1; bus.f_addr = 10'h006; #1;
        chk("t4_f_gnt", bus.f_gnt, 1);
        chk("t4_mem_en", bus.mem_en, 0);
        tick(); bus.f_req = 0;
        bus.l_req = 1; bus.l_we = 1; bus.l_addr = 10'h003; bus.l_wdata = 32'h1234_5678; #1;
        chk("t4_f_err", bus.f_err, 1);
        chk("t4_f_rdata", bus.f_rdata, 0);
        chk("t4_l_mem_en", bus.mem_en, 0);
        tick(); bus.l_we = 0; bus.l_addr = 10'h000; #1;
        chk("t4_l_err", bus.l_err, 1);
        chk("t4_l_rvalid", bus.l_rvalid, 1);
        tick(); bus.l_req = 0; #1;
        chk("t4_word0_unchanged", bus.l_rdata, 32'hA000_0000);

        // Fetch streaming, no bubbles
        tick(); bus.f_req = 1; bus.f_addr = 10'h000; #1;
        tick(); bus.f_addr = 10'h004; #1;
        chk("t5_s0", bus.f_rdata, 32'hA000_0000);
        tick(); bus.f_addr = 10'h008; #1;
        chk("t5_s1", bus.f_rdata, 32'hA000_0001);
        chk("t5_s1_valid", bus.f_rvalid, 1);
        tick(); bus.f_req = 0; #1;
        chk("t5_s2", bus.f_rdata, 32'hA000_0002);

        // Reset right after a grant drops its response
        tick(); bus.f_req = 1; bus.f_addr = 10'h010; #1;
        chk("t6_f_gnt", bus.f_gnt, 1);
        tick(); rst_n = 0; #1;
        chk("t6_no_rvalid", bus.f_rvalid, 0);
        chk("t6_no_gnt", bus.f_gnt, 0);
        tick(); bus.f_req = 0;
        tick(); rst_n = 1; #1;
        chk("t6_post_rvalid", bus.f_rvalid, 0);
        tick(); bus.f_req = 1; #1;
        chk("t6_resume_gnt", bus.f_gnt, 1);
        tick(); bus.f_req = 0; #1;
        chk("t6_resume_rdata", bus.f_rdata, 32'h0050_0093);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            tick();
            if (bus.f_req && !last_fg) begin
                if ($urandom_range(0, 3) == 0) bus.f_req = 0;
            end else begin
                bus.f_req  = ($urandom_range(0, 2) != 0);
                bus.f_addr = rand_addr();
            end
            if (bus.l_req && !last_lg) begin
                if ($urandom_range(0, 3) == 0) bus.l_req = 0;
            end else begin
                bus.l_req   = ($urandom_range(0, 2) != 0);
                bus.l_we    = 1'($urandom_range(0, 1));
                bus.l_addr  = rand_addr();
                bus.l_wdata = $urandom;
            end
            if ($urandom_range(0, 19) == 0) bus.l_lock = ~bus.l_lock;
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 399) == 0) rst_n = 0;
        end

        tick();
        bus.f_req = 0; bus.l_req = 0; bus.l_lock = 0; rst_n = 1;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
